// File: rtl/execute_issue_stage.sv
// Decode/execute pipeline register with execute-side operand forwarding.
// Produces the load-use stall and the branch-taken flush for fetch/decode.
// Optional feature macro: ZERO_REG_GUARD_EN. When it is defined, a bypass select
// whose source specifier is register 0 is latched as 0, so r0 always reads the
// regfile value.

`ifndef BEQ
`define BEQ 2'd1
`endif
`ifndef BNE
`define BNE 2'd2
`endif

module execute_issue_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      is_reg_write,
    input  logic                      is_mem_read,
    input  logic                      is_mem_write,
    input  logic                      is_immediate,
    input  logic [1:0]                BRANCH_OP,
    input  logic [3:0]                ALU_FUNCT,
    input  logic [REG_ADDR_WIDTH-1:0] DECODE_RS,
    input  logic [REG_ADDR_WIDTH-1:0] DECODE_RT,
    input  logic [REG_ADDR_WIDTH-1:0] DECODE_RD,
    input  logic [DATA_WIDTH-1:0]     RS_DATA,
    input  logic [DATA_WIDTH-1:0]     RT_DATA,
    input  logic [DATA_WIDTH-1:0]     IMM,
    input  logic [1:0]                BYPASS_1,
    input  logic [1:0]                BYPASS_2,
    input  logic [DATA_WIDTH-1:0]     EX_MEM_RESULT,
    input  logic [DATA_WIDTH-1:0]     MEM_WB_RESULT,
    output logic                      EX_is_reg_write,
    output logic                      EX_is_mem_read,
    output logic                      EX_is_mem_write,
    output logic [3:0]                EX_ALU_FUNCT,
    output logic [REG_ADDR_WIDTH-1:0] EX_RD,
    output logic [DATA_WIDTH-1:0]     OPERAND_A,
    output logic [DATA_WIDTH-1:0]     OPERAND_B,
    output logic [DATA_WIDTH-1:0]     STORE_DATA,
    output logic                      STALL,
    output logic                      FLUSH,
    output logic                      BRANCH_TAKEN
);

    logic                      ex_reg_write_q, ex_reg_write_d;
    logic                      ex_mem_read_q, ex_mem_read_d;
    logic                      ex_mem_write_q, ex_mem_write_d;
    logic                      ex_immediate_q, ex_immediate_d;
    logic [1:0]                ex_branch_op_q, ex_branch_op_d;
    logic [3:0]                ex_alu_funct_q, ex_alu_funct_d;
    logic [REG_ADDR_WIDTH-1:0] ex_rd_q, ex_rd_d;
    logic [DATA_WIDTH-1:0]     ex_rs_data_q, ex_rs_data_d;
    logic [DATA_WIDTH-1:0]     ex_rt_data_q, ex_rt_data_d;
    logic [DATA_WIDTH-1:0]     ex_imm_q, ex_imm_d;
    logic [1:0]                ex_bypass_1_q, ex_bypass_1_d;
    logic [1:0]                ex_bypass_2_q, ex_bypass_2_d;

    logic [DATA_WIDTH-1:0]     fwd_a, fwd_b;
    logic [1:0]                bypass_1_in, bypass_2_in;
    logic                      stall_raw, branch_taken;

    // Operand forwarding from the latched selects; select 3 falls back to the regfile.
    always_comb begin
        case (ex_bypass_1_q)
            2'd1:    fwd_a = EX_MEM_RESULT;
            2'd2:    fwd_a = MEM_WB_RESULT;
            default: fwd_a = ex_rs_data_q;
        endcase
        case (ex_bypass_2_q)
            2'd1:    fwd_b = EX_MEM_RESULT;
            2'd2:    fwd_b = MEM_WB_RESULT;
            default: fwd_b = ex_rt_data_q;
        endcase
    end

    // Branch resolution and load-use detection against the live decode bundle.
    always_comb begin
        branch_taken = ((ex_branch_op_q == `BEQ) && (fwd_a == fwd_b)) ||
                       ((ex_branch_op_q == `BNE) && (fwd_a != fwd_b));
        // RT only matters when decode actually reads it as a register operand.
        stall_raw    = ex_mem_read_q && (ex_rd_q != '0) &&
                       ((ex_rd_q == DECODE_RS) ||
                        ((ex_rd_q == DECODE_RT) &&
                         (!is_immediate || is_mem_write || (BRANCH_OP != 2'd0))));
    end

    assign OPERAND_A       = fwd_a;
    assign OPERAND_B       = ex_immediate_q ? ex_imm_q : fwd_b;
    assign STORE_DATA      = fwd_b;
    assign FLUSH           = branch_taken;
    assign BRANCH_TAKEN    = branch_taken;
    // A taken branch squashes decode, so its load-use hazard is moot.
    assign STALL           = stall_raw && !branch_taken;
    assign EX_is_reg_write = ex_reg_write_q;
    assign EX_is_mem_read  = ex_mem_read_q;
    assign EX_is_mem_write = ex_mem_write_q;
    assign EX_ALU_FUNCT    = ex_alu_funct_q;
    assign EX_RD           = ex_rd_q;

    // Bypass selects as they will be latched.
    always_comb begin
        bypass_1_in = BYPASS_1;
        bypass_2_in = BYPASS_2;
`ifdef ZERO_REG_GUARD_EN
        if (DECODE_RS == '0) bypass_1_in = 2'd0;
        if (DECODE_RT == '0) bypass_2_in = 2'd0;
`endif
    end

    // Next state: latch the decode bundle, or an all-zero bubble on flush/stall.
    always_comb begin
        ex_reg_write_d = is_reg_write;
        ex_mem_read_d  = is_mem_read;
        ex_mem_write_d = is_mem_write;
        ex_immediate_d = is_immediate;
        ex_branch_op_d = BRANCH_OP;
        ex_alu_funct_d = ALU_FUNCT;
        ex_rd_d        = DECODE_RD;
        ex_rs_data_d   = RS_DATA;
        ex_rt_data_d   = RT_DATA;
        ex_imm_d       = IMM;
        ex_bypass_1_d  = bypass_1_in;
        ex_bypass_2_d  = bypass_2_in;
        if (branch_taken || stall_raw) begin
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            ex_mem_write_d = 1'b0;
            ex_immediate_d = 1'b0;
            ex_branch_op_d = 2'd0;
            ex_alu_funct_d = 4'd0;
            ex_rd_d        = '0;
            ex_rs_data_d   = '0;
            ex_rt_data_d   = '0;
            ex_imm_d       = '0;
            ex_bypass_1_d  = 2'd0;
            ex_bypass_2_d  = 2'd0;
        end
    end

    // Pipeline register; reset leaves a bubble in execute.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_immediate_q <= 1'b0;
            ex_branch_op_q <= 2'd0;
            ex_alu_funct_q <= 4'd0;
            ex_rd_q        <= '0;
            ex_rs_data_q   <= '0;
            ex_rt_data_q   <= '0;
            ex_imm_q       <= '0;
            ex_bypass_1_q  <= 2'd0;
            ex_bypass_2_q  <= 2'd0;
        end else begin
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_mem_write_q <= ex_mem_write_d;
            ex_immediate_q <= ex_immediate_d;
            ex_branch_op_q <= ex_branch_op_d;
            ex_alu_funct_q <= ex_alu_funct_d;
            ex_rd_q        <= ex_rd_d;
            ex_rs_data_q   <= ex_rs_data_d;
            ex_rt_data_q   <= ex_rt_data_d;
            ex_imm_q       <= ex_imm_d;
            ex_bypass_1_q  <= ex_bypass_1_d;
            ex_bypass_2_q  <= ex_bypass_2_d;
        end
    end

endmodule

// File: tb/tb_execute_issue_stage.sv
// Scoreboard bench for execute_issue_stage: directed cases followed by random traffic,
// checked against an instruction-level model of the execute slot.

`ifndef BEQ
`define BEQ 2'd1
`endif
`ifndef BNE
`define BNE 2'd2
`endif

module tb_execute_issue_stage;

    typedef struct packed {
        logic        rw, mr, mw, ie;
        logic [1:0]  bop;
        logic [3:0]  fn;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic [1:0]  b1, b2;
    } bundle_t;

    typedef struct packed {
        logic        rw, mr, mw;
        logic [3:0]  fn;
        logic [4:0]  rd;
        logic [31:0] a, b, sd;
        logic        st, fl, chk_ops;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        is_reg_write = 0, is_mem_read = 0, is_mem_write = 0, is_immediate = 0;
    logic [1:0]  BRANCH_OP = 0, BYPASS_1 = 0, BYPASS_2 = 0;
    logic [3:0]  ALU_FUNCT = 0;
    logic [4:0]  DECODE_RS = 0, DECODE_RT = 0, DECODE_RD = 0;
    logic [31:0] RS_DATA = 0, RT_DATA = 0, IMM = 0, EX_MEM_RESULT = 0, MEM_WB_RESULT = 0;
    logic        EX_is_reg_write, EX_is_mem_read, EX_is_mem_write;
    logic [3:0]  EX_ALU_FUNCT;
    logic [4:0]  EX_RD;
    logic [31:0] OPERAND_A, OPERAND_B, STORE_DATA;
    logic        STALL, FLUSH, BRANCH_TAKEN;

    execute_issue_stage dut (
        .CLK(CLK), .RST(RST),
        .is_reg_write(is_reg_write), .is_mem_read(is_mem_read),
        .is_mem_write(is_mem_write), .is_immediate(is_immediate),
        .BRANCH_OP(BRANCH_OP), .ALU_FUNCT(ALU_FUNCT),
        .DECODE_RS(DECODE_RS), .DECODE_RT(DECODE_RT), .DECODE_RD(DECODE_RD),
        .RS_DATA(RS_DATA), .RT_DATA(RT_DATA), .IMM(IMM),
        .BYPASS_1(BYPASS_1), .BYPASS_2(BYPASS_2),
        .EX_MEM_RESULT(EX_MEM_RESULT), .MEM_WB_RESULT(MEM_WB_RESULT),
        .EX_is_reg_write(EX_is_reg_write), .EX_is_mem_read(EX_is_mem_read),
        .EX_is_mem_write(EX_is_mem_write), .EX_ALU_FUNCT(EX_ALU_FUNCT), .EX_RD(EX_RD),
        .OPERAND_A(OPERAND_A), .OPERAND_B(OPERAND_B), .STORE_DATA(STORE_DATA),
        .STALL(STALL), .FLUSH(FLUSH), .BRANCH_TAKEN(BRANCH_TAKEN)
    );

    always #5 CLK = ~CLK;

    int      checks = 0;
    int      errors = 0;
    exp_t    sb[$];
    bundle_t m_ex;          // instruction currently in execute
    logic    m_bubble = 0;  // execute holds a flush/stall bubble (operands undefined)
    logic    m_stall = 0;   // last cycle predicted a stall, so decode must re-present
    logic    prev_stall = 0;

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r,
                                         input logic [31:0] exm, input logic [31:0] mwb);
        if (sel == 2'd1) return exm;
        if (sel == 2'd2) return mwb;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: present decode bundle d and forwarding results, predict, advance model.
    task automatic step(input bundle_t d, input logic [31:0] exm, input logic [31:0] mwb,
                        input logic rst_v);
        exp_t        e;
        logic [31:0] a, b;
        logic        hazard, taken;
        @(posedge CLK);
        #1;
        RST = rst_v;
        is_reg_write = d.rw; is_mem_read = d.mr; is_mem_write = d.mw; is_immediate = d.ie;
        BRANCH_OP = d.bop; ALU_FUNCT = d.fn;
        DECODE_RS = d.rs; DECODE_RT = d.rt; DECODE_RD = d.rd;
        RS_DATA = d.rsd; RT_DATA = d.rtd; IMM = d.imm;
        BYPASS_1 = d.b1; BYPASS_2 = d.b2;
        EX_MEM_RESULT = exm; MEM_WB_RESULT = mwb;
        if (rst_v) begin
            m_ex = '0;
            m_bubble = 0;
        end
        a = pick(m_ex.b1, m_ex.rsd, exm, mwb);
        b = pick(m_ex.b2, m_ex.rtd, exm, mwb);
        taken = (m_ex.bop == `BEQ && a == b) || (m_ex.bop == `BNE && a != b);
        hazard = m_ex.mr && m_ex.rd != 0 &&
                 (m_ex.rd == d.rs || (m_ex.rd == d.rt && (!d.ie || d.mw || d.bop != 0)));
        e.rw = m_ex.rw; e.mr = m_ex.mr; e.mw = m_ex.mw; e.fn = m_ex.fn; e.rd = m_ex.rd;
        e.a = a; e.b = m_ex.ie ? m_ex.imm : b; e.sd = b;
        e.st = hazard && !taken; e.fl = taken; e.chk_ops = !m_bubble;
        sb.push_back(e);
        m_stall = e.st;
        if (rst_v) begin
            m_ex = '0;
            m_bubble = 0;
        end else if (taken || hazard) begin
            m_ex = '0;
            m_bubble = 1;
        end else begin
            m_ex = d;
`ifdef ZERO_REG_GUARD_EN
            if (d.rs == 0) m_ex.b1 = 2'd0;
            if (d.rt == 0) m_ex.b2 = 2'd0;
`endif
            m_bubble = 0;
        end
    endtask

    // Monitor: compare the DUT against the oldest prediction every cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ex_reg_write", 32'(EX_is_reg_write), 32'(e.rw));
            chk("ex_mem_read", 32'(EX_is_mem_read), 32'(e.mr));
            chk("ex_mem_write", 32'(EX_is_mem_write), 32'(e.mw));
            chk("ex_alu_funct", 32'(EX_ALU_FUNCT), 32'(e.fn));
            chk("ex_rd", 32'(EX_RD), 32'(e.rd));
            chk("stall", 32'(STALL), 32'(e.st));
            chk("flush", 32'(FLUSH), 32'(e.fl));
            chk("branch_taken", 32'(BRANCH_TAKEN), 32'(e.fl));
            if (e.chk_ops) begin
                chk("operand_a", OPERAND_A, e.a);
                chk("operand_b", OPERAND_B, e.b);
                chk("store_data", STORE_DATA, e.sd);
            end
            checks++;
            if (STALL && prev_stall) begin
                errors++;
                $display("FAIL stall_repeat got 2 consecutive stalls expected at most 1 at %0t",
                         $time);
            end
            prev_stall = STALL;
        end
    end

    initial begin
        bundle_t d, n;
        m_ex = '0;
        n = '0;
        repeat (2) @(posedge CLK);
        step(n, 0, 0, 0);  // reset state visible

        // Forwarding source per select value.
        d = '0; d.rw = 1; d.rs = 1; d.rsd = 32'h11; d.b1 = 1; d.fn = 4'h3; d.rd = 7;
        step(d, 0, 0, 0);
        d.b1 = 2;
        step(d, 32'hAA, 32'h55, 0);
        d.b1 = 3;
        step(d, 32'hAA, 32'h55, 0);
        step(n, 32'hAA, 32'h55, 0);

        // Immediate operand B with forwarded store data.
        d = '0; d.mw = 1; d.ie = 1; d.imm = 32'hFFFF_FFF0; d.b2 = 1; d.rt = 2; d.rtd = 32'h9;
        step(d, 0, 0, 0);
        step(n, 32'h1234_5678, 32'h0, 0);

        // Load-use: LW r5, then a consumer of r5 stalls exactly once.
        d = '0; d.rw = 1; d.mr = 1; d.rd = 5; d.fn = 4'h1;
        step(d, 0, 0, 0);
        d = '0; d.rw = 1; d.rs = 5; d.rt = 6; d.rd = 8; d.fn = 4'h2; d.rsd = 3;
        step(d, 0, 0, 0);
        step(d, 32'h77, 0, 0);
        step(n, 0, 32'h66, 0);

        // BEQ taken then not taken.
        d = '0; d.bop = `BEQ; d.rs = 1; d.rt = 2; d.rsd = 7; d.rtd = 7;
        step(d, 0, 0, 0);
        step(n, 0, 0, 0);
        d.rtd = 8;
        step(d, 0, 0, 0);
        step(n, 0, 0, 0);
        d = '0; d.bop = `BNE; d.rs = 1; d.rt = 2; d.rsd = 4; d.rtd = 4; d.b2 = 2;
        step(d, 0, 0, 0);
        step(n, 0, 32'h4, 0);

        // Flush and load-use together: stall suppressed, bubble latched.
        d = '0; d.mr = 1; d.rd = 5; d.bop = `BEQ; d.rs = 1; d.rt = 2; d.rsd = 7; d.rtd = 7;
        step(d, 0, 0, 0);
        d = '0; d.rw = 1; d.rs = 5; d.rd = 9; d.fn = 4'hF;
        step(d, 0, 0, 0);
        step(n, 0, 0, 0);

        // Register 0 as forwarding source.
        d = '0; d.rw = 1; d.rs = 0; d.rsd = 32'h0; d.b1 = 1; d.rd = 3;
        step(d, 0, 0, 0);
        step(n, 32'hDEAD_BEEF, 0, 0);

        // Reset mid-stream with a valid bundle in execute.
        d = '0; d.rw = 1; d.mr = 1; d.rd = 4; d.fn = 4'h6; d.rs = 1; d.rsd = 32'h21;
        step(d, 0, 0, 0);
        d.rs = 4;
        step(d, 0, 0, 1);
        step(d, 0, 0, 1);
        d = '0; d.rw = 1; d.rd = 11; d.fn = 4'h5; d.rs = 1; d.rsd = 32'h42;
        step(d, 0, 0, 0);
        step(n, 0, 0, 0);

        // Random traffic with a small register space to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            if (!m_stall) begin
                d.rw = 1'($urandom); d.mr = ($urandom_range(0, 2) != 0);
                d.mw = 1'($urandom); d.ie = 1'($urandom);
                d.bop = 2'($urandom); d.fn = 4'($urandom);
                d.rs = 5'($urandom_range(0, 3)); d.rt = 5'($urandom_range(0, 3));
                d.rd = 5'($urandom_range(0, 3));
                d.rsd = $urandom_range(0, 3); d.rtd = $urandom_range(0, 3);
                d.imm = $urandom; d.b1 = 2'($urandom); d.b2 = 2'($urandom);
            end
            step(d, $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 60) == 0));
        end
        step(n, 0, 0, 0);

        @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_issue_stage.md
Name: execute_issue_stage

Overview:
- Consumer end of the decode-stage control and bypass signals: the DECODE/EXECUTE pipeline register plus the execute-side operand forwarding.
- Latches the decoded control bundle, register data, immediate and bypass selects each cycle.
- Applies the bypass selects against live EX/MEM and MEM/WB results.
- Generates the load-use stall and the branch-taken flush back to fetch/decode.

Parameters:
DATA_WIDTH, 32, operand/result width
REG_ADDR_WIDTH, 5, register specifier width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
is_reg_write  in  1  decode control
is_mem_read  in  1  decode control
is_mem_write  in  1  decode control
is_immediate  in  1  decode control
BRANCH_OP  in  2  0=none, `BEQ, `BNE (opcode.v encodings)
ALU_FUNCT  in  4  decoded ALU function
DECODE_RS, DECODE_RT, DECODE_RD  in  REG_ADDR_WIDTH  decode specifiers
RS_DATA, RT_DATA, IMM  in  DATA_WIDTH  register file reads, sign-extended immediate
BYPASS_1, BYPASS_2  in  2  0=regfile, 1=EX/MEM, 2=MEM/WB, 3=treated as 0
EX_MEM_RESULT, MEM_WB_RESULT  in  DATA_WIDTH  forwarding sources
EX_is_reg_write, EX_is_mem_read, EX_is_mem_write  out  1  registered control
EX_ALU_FUNCT  out  4  registered
EX_RD  out  REG_ADDR_WIDTH  registered destination
OPERAND_A, OPERAND_B, STORE_DATA  out  DATA_WIDTH  forwarded operands
STALL  out  1  hold PC and decode register
FLUSH  out  1  branch taken; squash decode/fetch
BRANCH_TAKEN  out  1  equals FLUSH

Behaviour:
- Reset:
  - All EX control registers are 0, forming a bubble. EX_RD, EX_BRANCH_OP, latched data and latched bypass selects are 0.
  - As a result, OPERAND_A=0, OPERAND_B=0, STORE_DATA=0, STALL=0, FLUSH=0.
  - Reset asserted mid-operation discards the in-flight instruction immediately.
- Latency: one cycle. The decode bundle present at edge N is in execute during cycle N+1.
- Forwarding (combinational from the latched selects):
  - FWD_A = sel(EX_BYPASS_1: 0→EX_RS_DATA, 1→EX_MEM_RESULT, 2→MEM_WB_RESULT, 3→EX_RS_DATA).
  - FWD_B is formed the same way from EX_BYPASS_2 and EX_RT_DATA.
  - OPERAND_A = FWD_A.
  - OPERAND_B = EX_is_immediate ? EX_IMM : FWD_B.
  - STORE_DATA = FWD_B.
- Branch:
  - BRANCH_TAKEN = (EX_BRANCH_OP==`BEQ && FWD_A==FWD_B) || (EX_BRANCH_OP==`BNE && FWD_A!=FWD_B).
  - FLUSH = BRANCH_TAKEN.
- Load-use stall (combinational):
  - STALL = EX_is_mem_read && EX_RD!=0 && (EX_RD==DECODE_RS || (EX_RD==DECODE_RT && (!is_immediate || is_mem_write || BRANCH_OP!=0))).
- Next-state rules, in priority order:
  1. FLUSH=1: load a bubble (all control 0, BRANCH_OP 0). STALL is ignored and forced to 0 at the output.
  2. STALL=1: load a bubble. Decode holds, so the same instruction is re-presented next cycle and the stall resolves after one bubble.
  3. Otherwise: latch the full decode bundle.
- Bubble definition:
  - Data registers may load any value; control, BRANCH_OP and EX_RD are cleared.
  - The latched bypass selects are cleared to 0.
- A stall can never repeat more than one consecutive cycle for the same instruction. The bench checks this.

Optional Feature:
- Macro: ZERO_REG_GUARD_EN.
- Defined: when latching, a bypass select whose source specifier (DECODE_RS for BYPASS_1, DECODE_RT for BYPASS_2) is 0 is forced to 0, so register 0 always reads the regfile value.
- Undefined: bypass selects are latched unmodified.

Test Plan:
- Assert RST mid-stream with a valid bundle latched → outputs immediately 0, STALL=0, FLUSH=0; first edge after release latches the decode bundle.
- BYPASS_1=1, RS_DATA=0x11, EX_MEM_RESULT=0xAA (next cycle) → OPERAND_A=0xAA; BYPASS_1=2, MEM_WB_RESULT=0x55 → 0x55; BYPASS_1=3 → 0x11.
- Latch is_immediate=1, IMM=0xFFFFFFF0, BYPASS_2=1 → OPERAND_B=0xFFFFFFF0, STORE_DATA=EX_MEM_RESULT.
- LW with DECODE_RD=5 latched, decode presents RS=5 → STALL=1 one cycle, next EX control all 0, then the instruction latches normally with STALL=0.
- BRANCH_OP=`BEQ, RS_DATA=RT_DATA=7 latched → FLUSH=1, next cycle bubble; RT_DATA=8 → FLUSH=0.
- FLUSH and load-use in the same cycle → STALL output 0, bubble latched; with ZERO_REG_GUARD_EN, RS=0 and BYPASS_1=1 → OPERAND_A=RS_DATA.
